dm_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous data memory (`dm`) between the processor load/store path (port 0) and an external loader/debug path (port 1). It sits between the datapath and `dm`. It issues at most one memory access per cycle, returns read data one cycle after the grant, and stalls the losing requester. Port 1 can lock the memory for bursts; a bounded lock window prevents processor starvation.

---
 rtl/dm_arbiter_pkg.sv | 23 ++
 rtl/dm_arbiter_if.sv | 51 +++++
 rtl/dm_arbiter_rr_arb2.sv | 40 ++++
 rtl/dm_arbiter.sv | 139 +++++++++++++
 tb/tb_dm_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// Purpose: shared types and constants for the data-memory arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, port index constants, default bus widths,
//           and a 16-bit saturating increment helper.
package dm_arbiter_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic P_CPU = 1'b0;
    localparam logic P_LDR = 1'b1;

    localparam int DM_AW = 8;
    localparam int DM_DW = 24;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Purpose: bundle of both requester ports and the memory command/return bus.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/we/addr/wdata until their gnt is seen.
// Ports: p0_* processor port, p1_* loader/debug port (plus p1_lock),
//        mem_* single-port memory side. slave = arbiter, master = environment.
interface dm_arbiter_if import dm_arbiter_pkg::*; #(
    parameter int AW = DM_AW,
    parameter int DW = DM_DW
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_lock;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Purpose: two-way round-robin pick with registered priority pointer.
// Latency: grant is combinational (0 cycles); pointer updates on the edge.
// Backpressure: the losing request simply sees no grant and must hold.
// Ports: clk/rst; req[1:0] requests; en gates the pick; ptr_set forces the
//        pointer to P_CPU; gnt[1:0] one-hot (or zero) grant.
module rr_arb2 import dm_arbiter_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       ptr_set,
    output logic [1:0] gnt
);

    logic ptr_q;

    // A lone requester always wins; on a tie the pointer port wins.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt[ptr_q] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    // After any grant the pointer favours the other port next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= P_CPU;
        end else if (ptr_set) begin
            ptr_q <= P_CPU;
        end else if (gnt != 2'b00) begin
            ptr_q <= gnt[P_CPU] ? P_LDR : P_CPU;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Purpose: shares the single-port data memory between CPU (p0) and loader (p1).
// Latency: grant 0 cycles (combinational); read data 1 cycle after grant.
// Backpressure: loser sees no gnt and holds its request (CPU stall = p0_req & ~p0_gnt).
// Ports: clk, rst (sync, active-high); bus (dm_arbiter_if.slave) carrying both
//        requester ports and the memory bus; conflict_cnt saturating deny count.
module dm_arbiter import dm_arbiter_pkg::*; #(
    parameter int AW       = DM_AW,
    parameter int DW       = DM_DW,
    parameter int LOCK_MAX = 16
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus,
    output logic [15:0]  conflict_cnt
);

    localparam logic [7:0] LOCK_MAX_C = LOCK_MAX[7:0];

    arb_state_t    state_q, state_d;
    logic [7:0]    lock_cnt_q, lock_cnt_d;
    logic [1:0]    rr_gnt;
    logic          rr_en;
    logic          ptr_set;
    logic          p0_gnt, p1_gnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          rd_vld_q;
    logic          rd_owner_q;
    logic          conflict;
    logic [15:0]   conflict_q;

    // Round-robin pick only matters in ARB; LOCKED overrides it.
    assign rr_en = ~rst & (state_q == ARB);

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.p1_req, bus.p0_req}),
        .en      (rr_en),
        .ptr_set (ptr_set),
        .gnt     (rr_gnt)
    );

    // Next-state, lock counter and grants. All grants are held low in reset.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        ptr_set    = 1'b0;
        p0_gnt     = 1'b0;
        p1_gnt     = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ARB: begin
                    p0_gnt = rr_gnt[P_CPU];
                    p1_gnt = rr_gnt[P_LDR];
                    if (p1_gnt && bus.p1_lock) begin
                        lock_cnt_d = 8'd1;
                        // With a window of one grant the lock is already used
                        // up; the pointer has moved to P_CPU via the grant.
                        if (LOCK_MAX_C != 8'd1) begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    p1_gnt = bus.p1_req;
                    if (p1_gnt) begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end
                    if (!bus.p1_lock) begin
                        state_d = ARB;
                    end else if (lock_cnt_d == LOCK_MAX_C) begin
                        // Forced release: CPU gets first shot at the memory.
                        state_d = ARB;
                        ptr_set = 1'b1;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    // Command mux: fields are zero when nothing is granted.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p1_gnt) begin
            mem_we    = bus.p1_we;
            mem_addr  = bus.p1_addr;
            mem_wdata = bus.p1_wdata;
        end else if (p0_gnt) begin
            mem_we    = bus.p0_we;
            mem_addr  = bus.p0_addr;
            mem_wdata = bus.p0_wdata;
        end
    end

    assign mem_en   = p0_gnt | p1_gnt;
    assign conflict = (bus.p0_req & ~p0_gnt) | (bus.p1_req & ~p1_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            lock_cnt_q <= 8'd0;
            rd_vld_q   <= 1'b0;
            rd_owner_q <= P_CPU;
            conflict_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            rd_vld_q   <= mem_en & ~mem_we;
            rd_owner_q <= p1_gnt ? P_LDR : P_CPU;
            if (conflict) begin
                conflict_q <= sat_inc16(conflict_q);
            end
        end
    end

    assign bus.p0_gnt    = p0_gnt;
    assign bus.p1_gnt    = p1_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    // Read return is steered to the port that owned the read; the
    // synchronous reset is not yet visible in the register during the first
    // reset cycle, so rvalid is also gated by rst directly.
    assign bus.p0_rvalid = ~rst & rd_vld_q & (rd_owner_q == P_CPU);
    assign bus.p1_rvalid = ~rst & rd_vld_q & (rd_owner_q == P_LDR);
    assign bus.p0_rdata  = bus.p0_rvalid ? bus.mem_rdata : '0;
    assign bus.p1_rdata  = bus.p1_rvalid ? bus.mem_rdata : '0;

    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] conflict_cnt;
    logic [23:0] mem [0:255];

    int n_vec = 0;
    int n_err = 0;

    dm_arbiter_if #(.AW(8), .DW(24)) bus ();

    dm_arbiter #(.AW(8), .DW(24), .LOCK_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory model.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic clear_inputs();
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 8'h00; bus.p0_wdata = 24'h0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 8'h00; bus.p1_wdata = 24'h0;
        bus.p1_lock = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        bus.p0_req = 1'b1; bus.p0_addr = 8'h33; bus.p0_wdata = 24'h111111; bus.p0_we = 1'b1;
        bus.p1_req = 1'b1; bus.p1_addr = 8'h44;
        #1;
        n_vec++; if (bus.p0_gnt !== 1'b0) begin n_err++; $display("FAIL rst_p0_gnt: got %b want 0", bus.p0_gnt); end
        n_vec++; if (bus.p1_gnt !== 1'b0) begin n_err++; $display("FAIL rst_p1_gnt: got %b want 0", bus.p1_gnt); end
        n_vec++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); end
        n_vec++; if (bus.mem_addr !== 8'h00) begin n_err++; $display("FAIL rst_mem_addr: got %h want 00", bus.mem_addr); end
        n_vec++; if (bus.mem_wdata !== 24'h0) begin n_err++; $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); end
        step();
        clear_inputs();
        rst = 1'b0;
        bus.p0_addr = 8'h5A; bus.p0_wdata = 24'h777777; bus.p0_we = 1'b1;
        #1;
        n_vec++; if (conflict_cnt !== 16'd0) begin n_err++; $display("FAIL rst_conflict: got %0d want 0", conflict_cnt); end
        n_vec++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin n_err++; $display("FAIL idle_mem_en_we: got %b%b want 00", bus.mem_en, bus.mem_we); end
        n_vec++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 24'h0) begin n_err++; $display("FAIL idle_mem_fields: got %h/%h want 00/000000", bus.mem_addr, bus.mem_wdata); end
        n_vec++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin n_err++; $display("FAIL idle_rvalid: got %b%b want 00", bus.p0_rvalid, bus.p1_rvalid); end
        clear_inputs();
    endtask

    task automatic test_single_read();
        // Preload address 05 through port 0.
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 8'h05; bus.p0_wdata = 24'hABCDEF;
        #1;
        n_vec++; if (bus.p0_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin n_err++; $display("FAIL wr_gnt: got gnt=%b we=%b want 1 1", bus.p0_gnt, bus.mem_we); end
        n_vec++; if (bus.mem_wdata !== 24'hABCDEF) begin n_err++; $display("FAIL wr_wdata: got %h want abcdef", bus.mem_wdata); end
        step();
        bus.p0_we = 1'b0; bus.p0_wdata = 24'h0;
        #1;
        n_vec++; if (bus.p0_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %b want 0", bus.p0_rvalid); end
        n_vec++; if (bus.p0_gnt !== 1'b1 || bus.mem_addr !== 8'h05) begin n_err++; $display("FAIL rd_gnt: got gnt=%b addr=%h want 1 05", bus.p0_gnt, bus.mem_addr); end
        step();
        clear_inputs();
        #1;
        n_vec++; if (bus.p0_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_rvalid: got %b want 1", bus.p0_rvalid); end
        n_vec++; if (bus.p0_rdata !== 24'hABCDEF) begin n_err++; $display("FAIL rd_rdata: got %h want abcdef", bus.p0_rdata); end
        n_vec++; if (bus.p1_rvalid !== 1'b0 || bus.p1_rdata !== 24'h0) begin n_err++; $display("FAIL rd_other_port: got %b/%h want 0/000000", bus.p1_rvalid, bus.p1_rdata); end
        step();
        #1;
        n_vec++; if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 24'h0) begin n_err++; $display("FAIL rd_one_shot: got %b/%h want 0/000000", bus.p0_rvalid, bus.p0_rdata); end
    endtask

    task automatic test_alternate();
        logic exp0;
        do_reset();
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 8'h20; bus.p0_wdata = 24'h000020;
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 8'h21; bus.p1_wdata = 24'h000021;
        for (int i = 0; i < 6; i++) begin
            exp0 = (i % 2 == 0);
            #1;
            n_vec++; if (bus.p0_gnt !== exp0 || bus.p1_gnt !== ~exp0) begin n_err++; $display("FAIL alt_cycle%0d: got p0=%b p1=%b want p0=%b p1=%b", i, bus.p0_gnt, bus.p1_gnt, exp0, ~exp0); end
            step();
        end
        clear_inputs();
        #1;
        n_vec++; if (conflict_cnt !== 16'd6) begin n_err++; $display("FAIL alt_conflict: got %0d want 6", conflict_cnt); end
    endtask

    task automatic test_lock();
        logic [13:0] p0_req_v = 14'b11011111111110;
        logic [13:0] p1_req_v = 14'b00111101111111;
        logic [13:0] lock_v   = 14'b00111111111111;
        logic [13:0] exp0_v   = 14'b10010000010000;
        logic [13:0] exp1_v   = 14'b00101101101111;
        bus.p0_we = 1'b1; bus.p0_addr = 8'h30; bus.p0_wdata = 24'h000030;
        bus.p1_we = 1'b1; bus.p1_addr = 8'h31; bus.p1_wdata = 24'h000031;
        for (int i = 0; i < 14; i++) begin
            bus.p0_req  = p0_req_v[i];
            bus.p1_req  = p1_req_v[i];
            bus.p1_lock = lock_v[i];
            #1;
            n_vec++; if (bus.p0_gnt !== exp0_v[i]) begin n_err++; $display("FAIL lock_p0_c%0d: got %b want %b", i, bus.p0_gnt, exp0_v[i]); end
            n_vec++; if (bus.p1_gnt !== exp1_v[i]) begin n_err++; $display("FAIL lock_p1_c%0d: got %b want %b", i, bus.p1_gnt, exp1_v[i]); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 8'h10; bus.p1_wdata = 24'h123456;
        #1;
        n_vec++; if (bus.p1_gnt !== 1'b1 || bus.mem_addr !== 8'h10) begin n_err++; $display("FAIL b2b_wr: got gnt=%b addr=%h want 1 10", bus.p1_gnt, bus.mem_addr); end
        step();
        clear_inputs();
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 8'h10;
        #1;
        n_vec++; if (bus.p0_gnt !== 1'b1 || bus.p1_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_rd: got gnt=%b p1_rvalid=%b want 1 0", bus.p0_gnt, bus.p1_rvalid); end
        step();
        clear_inputs();
        #1;
        n_vec++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 24'h123456) begin n_err++; $display("FAIL b2b_rdata: got %b/%h want 1/123456", bus.p0_rvalid, bus.p0_rdata); end
        n_vec++; if (bus.p1_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_p1_rvalid: got %b want 0", bus.p1_rvalid); end
        step();
    endtask

    task automatic test_reset_mid_read();
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 8'h10;
        #1;
        n_vec++; if (bus.p1_gnt !== 1'b1) begin n_err++; $display("FAIL rmr_gnt: got %b want 1", bus.p1_gnt); end
        step();
        rst = 1'b1;
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 8'h05;
        #1;
        n_vec++; if (bus.p1_rvalid !== 1'b0 || bus.p1_rdata !== 24'h0) begin n_err++; $display("FAIL rmr_rvalid: got %b/%h want 0/000000", bus.p1_rvalid, bus.p1_rdata); end
        n_vec++; if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0 || bus.mem_en !== 1'b0) begin n_err++; $display("FAIL rmr_gnts: got %b%b%b want 000", bus.p0_gnt, bus.p1_gnt, bus.mem_en); end
        n_vec++; if (bus.mem_addr !== 8'h00 || bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rmr_mem: got %h/%b want 00/0", bus.mem_addr, bus.mem_we); end
        step();
        rst = 1'b0;
        #1;
        n_vec++; if (bus.p1_rvalid !== 1'b0) begin n_err++; $display("FAIL rmr_discard: got %b want 0", bus.p1_rvalid); end
        n_vec++; if (conflict_cnt !== 16'd0) begin n_err++; $display("FAIL rmr_conflict: got %0d want 0", conflict_cnt); end
        n_vec++; if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin n_err++; $display("FAIL rmr_tie: got p0=%b p1=%b want 1 0", bus.p0_gnt, bus.p1_gnt); end
        step();
        #1;
        n_vec++; if (bus.p1_gnt !== 1'b1 || bus.p0_rvalid !== 1'b1) begin n_err++; $display("FAIL rmr_next: got p1_gnt=%b p0_rvalid=%b want 1 1", bus.p1_gnt, bus.p0_rvalid); end
        step();
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 8'h40;
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 8'h41;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++; if (conflict_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre: got %h want fffe", conflict_cnt); end
        step();
        #1;
        n_vec++; if (conflict_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach: got %h want ffff", conflict_cnt); end
        step();
        step();
        #1;
        n_vec++; if (conflict_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_alternate();
        test_lock();
        test_back_to_back();
        test_reset_mid_read();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
